// File: rtl/vote_pkg.sv
// Shared encodings and helpers for the weighted vote session tallier.
package vote_pkg;

  typedef enum logic [1:0] {
    MODE_MAJ  = 2'd0,
    MODE_2_3  = 2'd1,
    MODE_UNAN = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Weight of a ballot in which every voter says yes; every accepted ballot adds this to the cast tally.
  function automatic int ballot_cast_weight(input int np_w, input int vip_w, input int w_np,
                                            input int w_vip, input int w_vvip);
    return np_w * w_np + vip_w * w_vip + w_vvip;
  endfunction

endpackage

// File: rtl/vote_session_tally_if.sv
// Ballot/control inputs and tally/result outputs of the session tallier.
interface vote_session_tally_if #(
  parameter int NP_W  = 32,
  parameter int VIP_W = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             close;
  logic [1:0]       mode;
  logic             ballot_valid;
  logic [NP_W-1:0]  np;
  logic [VIP_W-1:0] vip;
  logic             vvip;
  logic             busy;
  logic [CNT_W-1:0] yes_cnt;
  logic [CNT_W-1:0] cast_cnt;
  logic             res_valid;
  logic             res;

  modport master (
    output start, close, mode, ballot_valid, np, vip, vvip,
    input  busy, yes_cnt, cast_cnt, res_valid, res
  );

  modport slave (
    input  start, close, mode, ballot_valid, np, vip, vvip,
    output busy, yes_cnt, cast_cnt, res_valid, res
  );
endinterface

// File: rtl/vote_session_tally_weighted_popcount.sv
// Combinational yes-weight of one ballot: weighted count of set voter bits.
module weighted_popcount #(
  parameter int NP_W   = 32,
  parameter int VIP_W  = 8,
  parameter int W_NP   = 1,
  parameter int W_VIP  = 4,
  parameter int W_VVIP = 16,
  parameter int OUT_W  = 7
) (
  input  logic [NP_W-1:0]  np,
  input  logic [VIP_W-1:0] vip,
  input  logic             vvip,
  output logic [OUT_W-1:0] yes_weight
);
  localparam int NP_CW  = $clog2(NP_W + 1);
  localparam int VIP_CW = $clog2(VIP_W + 1);

  logic [NP_CW-1:0]  np_ones;
  logic [VIP_CW-1:0] vip_ones;

  // Count yes bits per class, then scale each class by its weight.
  always_comb begin
    np_ones  = '0;
    vip_ones = '0;
    for (int i = 0; i < NP_W; i++) begin
      np_ones = np_ones + NP_CW'(np[i]);
    end
    for (int i = 0; i < VIP_W; i++) begin
      vip_ones = vip_ones + VIP_CW'(vip[i]);
    end
    yes_weight = OUT_W'(np_ones) * OUT_W'(W_NP)
               + OUT_W'(vip_ones) * OUT_W'(W_VIP)
               + (vvip ? OUT_W'(W_VVIP) : '0);
  end
endmodule

// File: rtl/vote_session_tally.sv
// Session-based weighted vote tallier: accumulates ballots while open, decides on close.
module vote_session_tally
  import vote_pkg::*;
#(
  parameter int NP_W        = 32,
  parameter int VIP_W       = 8,
  parameter int W_NP        = 1,
  parameter int W_VIP       = 4,
  parameter int W_VVIP      = 16,
  parameter int CNT_W       = 16,
  parameter int MAX_BALLOTS = 255
) (
  input logic                  clk,
  input logic                  reset,
  vote_session_tally_if.slave  bus
);
  localparam int CAST_W = ballot_cast_weight(NP_W, VIP_W, W_NP, W_VIP, W_VVIP);
  localparam int BW_W   = $clog2(CAST_W + 1);
  localparam int SUM_W  = ((CNT_W > BW_W) ? CNT_W : BW_W) + 1;
  localparam int BCNT_W = (MAX_BALLOTS > 1) ? $clog2(MAX_BALLOTS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  yes_q, yes_d;
  logic [CNT_W-1:0]  cast_q, cast_d;
  logic [BCNT_W-1:0] nb_q, nb_d;
  logic              res_q, res_d;
  logic [BW_W-1:0]   ballot_yes;
  logic [SUM_W-1:0]  yes_sum;
  logic [SUM_W-1:0]  cast_sum;
  logic              limit_hit;

  weighted_popcount #(
    .NP_W(NP_W), .VIP_W(VIP_W), .W_NP(W_NP), .W_VIP(W_VIP), .W_VVIP(W_VVIP), .OUT_W(BW_W)
  ) u_wpop (
    .np(bus.np), .vip(bus.vip), .vvip(bus.vvip), .yes_weight(ballot_yes)
  );

  // Decision rule on saturated final tallies; products are held in CNT_W+2 bits so they cannot overflow.
  function automatic logic decide(input logic [CNT_W-1:0] y, input logic [CNT_W-1:0] c,
                                  input logic [1:0] m);
    logic [CNT_W+1:0] y_ext;
    logic [CNT_W+1:0] c_ext;
    logic             r;
    y_ext = {2'b00, y};
    c_ext = {2'b00, c};
    case (mode_e'(m))
      MODE_2_3:  r = (y_ext * (CNT_W+2)'(3)) >= (c_ext * (CNT_W+2)'(2));
      MODE_UNAN: r = (y == c);
      default:   r = (y_ext * (CNT_W+2)'(2)) > c_ext;
    endcase
    return r && (c != '0);
  endfunction

  // Session FSM, saturating accumulation, ballot limit and evaluation on entry to DONE.
  always_comb begin
    state_d   = state_q;
    yes_d     = yes_q;
    cast_d    = cast_q;
    nb_d      = nb_q;
    res_d     = res_q;
    limit_hit = 1'b0;
    yes_sum   = SUM_W'(yes_q) + SUM_W'(ballot_yes);
    cast_sum  = SUM_W'(cast_q) + SUM_W'(CAST_W);
    case (state_q)
      S_OPEN: begin
        if (bus.start) begin
          yes_d  = '0;
          cast_d = '0;
          nb_d   = '0;
        end else begin
          if (bus.ballot_valid) begin
            yes_d     = (yes_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : yes_sum[CNT_W-1:0];
            cast_d    = (cast_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cast_sum[CNT_W-1:0];
            nb_d      = nb_q + BCNT_W'(1);
            limit_hit = (MAX_BALLOTS != 0) && (nb_q == BCNT_W'(MAX_BALLOTS - 1));
          end
          if (bus.close || limit_hit) begin
            state_d = S_DONE;
            res_d   = decide(yes_d, cast_d, bus.mode);
          end
        end
      end
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_OPEN;
          yes_d   = '0;
          cast_d  = '0;
          nb_d    = '0;
          res_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and tally registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      yes_q   <= '0;
      cast_q  <= '0;
      nb_q    <= '0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      yes_q   <= yes_d;
      cast_q  <= cast_d;
      nb_q    <= nb_d;
      res_q   <= res_d;
    end
  end

  assign bus.busy      = (state_q == S_OPEN);
  assign bus.res_valid = (state_q == S_DONE);
  assign bus.res       = res_q;
  assign bus.yes_cnt   = yes_q;
  assign bus.cast_cnt  = cast_q;
endmodule

// File: tb/tb_vote_session_tally.sv
// Bench for vote_session_tally: three configurations share one stimulus stream and are
// checked against a queue-based reference model.
module tb_vote_session_tally;
  import vote_pkg::*;

  typedef struct packed {
    logic        res;
    logic [31:0] yes;
    logic [31:0] cast;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start, close, ballot_valid, vvip;
  logic [1:0]  mode;
  logic [31:0] np;
  logic [7:0]  vip;

  int total = 0;
  int bad = 0;

  // Configurations: 0 default, 1 limit of four ballots, 2 eight-bit tallies with no limit.
  int cfg_cntw [3] = '{16, 16, 8};
  int cfg_max  [3] = '{255, 4, 0};

  bit          m_open [3];
  bit          m_done [3];
  int unsigned m_yes  [3];
  int unsigned m_cast [3];
  int unsigned m_nb   [3];
  exp_t        sb_q   [3][$];
  exp_t        pred;
  exp_t        got;
  logic        prev_rv [3];

  logic [31:0] o_yes  [3];
  logic [31:0] o_cast [3];
  logic        o_busy [3];
  logic        o_rv   [3];
  logic        o_res  [3];

  always #5 clk = ~clk;

  vote_session_tally_if #(.NP_W(32), .VIP_W(8), .CNT_W(16)) if0 ();
  vote_session_tally_if #(.NP_W(32), .VIP_W(8), .CNT_W(16)) if1 ();
  vote_session_tally_if #(.NP_W(32), .VIP_W(8), .CNT_W(8))  if2 ();

  assign if0.start = start;  assign if0.close = close;  assign if0.mode = mode;
  assign if0.ballot_valid = ballot_valid;  assign if0.np = np;  assign if0.vip = vip;  assign if0.vvip = vvip;
  assign if1.start = start;  assign if1.close = close;  assign if1.mode = mode;
  assign if1.ballot_valid = ballot_valid;  assign if1.np = np;  assign if1.vip = vip;  assign if1.vvip = vvip;
  assign if2.start = start;  assign if2.close = close;  assign if2.mode = mode;
  assign if2.ballot_valid = ballot_valid;  assign if2.np = np;  assign if2.vip = vip;  assign if2.vvip = vvip;

  vote_session_tally #(.CNT_W(16), .MAX_BALLOTS(255)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  vote_session_tally #(.CNT_W(16), .MAX_BALLOTS(4))   dut1 (.clk(clk), .reset(reset), .bus(if1));
  vote_session_tally #(.CNT_W(8),  .MAX_BALLOTS(0))   dut2 (.clk(clk), .reset(reset), .bus(if2));

  assign o_yes[0] = 32'(if0.yes_cnt);  assign o_cast[0] = 32'(if0.cast_cnt);
  assign o_yes[1] = 32'(if1.yes_cnt);  assign o_cast[1] = 32'(if1.cast_cnt);
  assign o_yes[2] = 32'(if2.yes_cnt);  assign o_cast[2] = 32'(if2.cast_cnt);
  assign o_busy[0] = if0.busy;  assign o_rv[0] = if0.res_valid;  assign o_res[0] = if0.res;
  assign o_busy[1] = if1.busy;  assign o_rv[1] = if1.res_valid;  assign o_res[1] = if1.res;
  assign o_busy[2] = if2.busy;  assign o_rv[2] = if2.res_valid;  assign o_res[2] = if2.res;

  function automatic int unsigned sat(input int unsigned v, input int w);
    int unsigned mx;
    mx = (32'd1 << w) - 32'd1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int unsigned yes_of(input logic [31:0] n, input logic [7:0] v, input logic vv);
    return $countones(n) * 1 + $countones(v) * 4 + (vv ? 16 : 0);
  endfunction

  function automatic logic decide_ref(input int unsigned y, input int unsigned c, input logic [1:0] m);
    if (c == 0) return 1'b0;
    case (m)
      2'd1:    return (3 * y) >= (2 * c);
      2'd2:    return y == c;
      default: return (2 * y) > c;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs shortly after a rising edge; they take effect on the next edge.
  task automatic applyStimulus(input logic s, input logic c, input logic [1:0] m, input logic v,
                               input logic [31:0] n, input logic [7:0] vi, input logic vv);
    @(posedge clk);
    #2;
    start = s;  close = c;  mode = m;  ballot_valid = v;  np = n;  vip = vi;  vvip = vv;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, MODE_MAJ, 1'b0, 32'h0, 8'h0, 1'b0);
  endtask

  // Reset pulse between clock edges; outputs must clear before any edge arrives.
  task automatic pulseReset();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("async reset dut%0d busy", k), 32'(o_busy[k]), 32'd0);
      checkOutput($sformatf("async reset dut%0d yes", k), o_yes[k], 32'd0);
      checkOutput($sformatf("async reset dut%0d cast", k), o_cast[k], 32'd0);
      checkOutput($sformatf("async reset dut%0d res_valid", k), 32'(o_rv[k]), 32'd0);
      checkOutput($sformatf("async reset dut%0d res", k), 32'(o_res[k]), 32'd0);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Reference model: session rules applied per configuration at each edge; predictions queued on close.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int k = 0; k < 3; k++) begin
          m_open[k] = 1'b0;  m_done[k] = 1'b0;
          m_yes[k] = 0;  m_cast[k] = 0;  m_nb[k] = 0;
          sb_q[k].delete();
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (start) begin
            m_open[k] = 1'b1;  m_done[k] = 1'b0;
            m_yes[k] = 0;  m_cast[k] = 0;  m_nb[k] = 0;
          end else if (m_open[k]) begin
            if (ballot_valid) begin
              m_yes[k]  = m_yes[k] + yes_of(np, vip, vvip);
              m_cast[k] = m_cast[k] + (32 * 1 + 8 * 4 + 16);
              m_nb[k]   = m_nb[k] + 1;
            end
            if (close || (ballot_valid && cfg_max[k] != 0 && m_nb[k] == cfg_max[k])) begin
              m_open[k] = 1'b0;
              m_done[k] = 1'b1;
              pred.yes  = sat(m_yes[k], cfg_cntw[k]);
              pred.cast = sat(m_cast[k], cfg_cntw[k]);
              pred.res  = decide_ref(pred.yes, pred.cast, mode);
              sb_q[k].push_back(pred);
            end
          end
        end
      end
    end
  end

  // Monitor: status against the model every cycle, and result against the queued prediction on res_valid.
  initial begin
    for (int k = 0; k < 3; k++) prev_rv[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("dut%0d busy", k), 32'(o_busy[k]), 32'(m_open[k]));
        checkOutput($sformatf("dut%0d res_valid", k), 32'(o_rv[k]), 32'(m_done[k]));
        checkOutput($sformatf("dut%0d yes_cnt", k), o_yes[k], sat(m_yes[k], cfg_cntw[k]));
        checkOutput($sformatf("dut%0d cast_cnt", k), o_cast[k], sat(m_cast[k], cfg_cntw[k]));
        if (o_rv[k] === 1'b1 && prev_rv[k] !== 1'b1) begin
          checkOutput($sformatf("dut%0d prediction available", k), 32'(sb_q[k].size() > 0), 32'd1);
          if (sb_q[k].size() > 0) begin
            got = sb_q[k].pop_front();
            checkOutput($sformatf("dut%0d sb res", k), 32'(o_res[k]), 32'(got.res));
            checkOutput($sformatf("dut%0d sb yes", k), o_yes[k], got.yes);
            checkOutput($sformatf("dut%0d sb cast", k), o_cast[k], got.cast);
          end
        end
        prev_rv[k] = o_rv[k];
      end
    end
  end

  // Directed scenarios first, then a randomized stream with occasional resets.
  initial begin
    start = 1'b0;  close = 1'b0;  mode = MODE_MAJ;  ballot_valid = 1'b0;
    np = '0;  vip = '0;  vvip = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset dut%0d busy", k), 32'(o_busy[k]), 32'd0);
      checkOutput($sformatf("reset dut%0d res_valid", k), 32'(o_rv[k]), 32'd0);
      checkOutput($sformatf("reset dut%0d yes", k), o_yes[k], 32'd0);
    end
    reset = 1'b0;

    // Ballot in IDLE is ignored.
    applyStimulus(1'b0, 1'b0, MODE_MAJ, 1'b1, 32'hffffffff, 8'hff, 1'b1);
    idleCycle();
    checkOutput("idle ballot ignored", o_yes[0], 32'd0);

    // One mixed ballot, majority.
    applyStimulus(1'b1, 1'b0, MODE_MAJ, 1'b0, 32'h0, 8'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, MODE_MAJ, 1'b1, 32'hf00f000f, 8'h0f, 1'b1);
    applyStimulus(1'b0, 1'b1, MODE_MAJ, 1'b0, 32'h0, 8'h0, 1'b0);
    checkOutput("t1 yes", o_yes[0], 32'd44);
    checkOutput("t1 no result yet", 32'(o_rv[0]), 32'd0);
    idleCycle();
    checkOutput("t1 res_valid", 32'(o_rv[0]), 32'd1);
    checkOutput("t1 res", 32'(o_res[0]), 32'd1);
    checkOutput("t1 cast", o_cast[0], 32'd80);

    // Same ballot without VVIP, majority then two-thirds.
    for (int m = 0; m < 2; m++) begin
      applyStimulus(1'b1, 1'b0, 2'(m), 1'b0, 32'h0, 8'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'(m), 1'b1, 32'hf00f000f, 8'h0f, 1'b0);
      applyStimulus(1'b0, 1'b1, 2'(m), 1'b0, 32'h0, 8'h0, 1'b0);
      idleCycle();
      checkOutput($sformatf("t2 mode%0d yes", m), o_yes[0], 32'd28);
      checkOutput($sformatf("t2 mode%0d res", m), 32'(o_res[0]), 32'd0);
    end

    // Unanimous: three full ballots, then one bit missing.
    for (int flip = 0; flip < 2; flip++) begin
      applyStimulus(1'b1, 1'b0, MODE_UNAN, 1'b0, 32'h0, 8'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, MODE_UNAN, 1'b1, 32'hffffffff, 8'hff, 1'b1);
      applyStimulus(1'b0, 1'b0, MODE_UNAN, 1'b1, (flip != 0) ? 32'hfffffffe : 32'hffffffff, 8'hff, 1'b1);
      applyStimulus(1'b0, 1'b0, MODE_UNAN, 1'b1, 32'hffffffff, 8'hff, 1'b1);
      applyStimulus(1'b0, 1'b1, MODE_UNAN, 1'b0, 32'h0, 8'h0, 1'b0);
      idleCycle();
      checkOutput($sformatf("t3 flip%0d cast", flip), o_cast[0], 32'd240);
      checkOutput($sformatf("t3 flip%0d res", flip), 32'(o_res[0]), (flip != 0) ? 32'd0 : 32'd1);
    end

    // Six full ballots: ballot limit on dut1, saturation on dut2.
    applyStimulus(1'b1, 1'b0, MODE_UNAN, 1'b0, 32'h0, 8'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, MODE_UNAN, 1'b1, 32'hffffffff, 8'hff, 1'b1);
      if (i == 4) begin
        checkOutput("t4 limit res_valid", 32'(o_rv[1]), 32'd1);
        checkOutput("t4 limit cast", o_cast[1], 32'd320);
        checkOutput("t4 limit res", 32'(o_res[1]), 32'd1);
        checkOutput("t4 no limit busy", 32'(o_busy[0]), 32'd1);
      end
    end
    applyStimulus(1'b0, 1'b1, MODE_UNAN, 1'b0, 32'h0, 8'h0, 1'b0);
    checkOutput("t4 extra ballots ignored", o_cast[1], 32'd320);
    checkOutput("t5 yes saturated", o_yes[2], 32'd255);
    checkOutput("t5 cast saturated", o_cast[2], 32'd255);
    checkOutput("t4 default cast", o_cast[0], 32'd480);
    idleCycle();
    checkOutput("t5 saturated res", 32'(o_res[2]), 32'd1);

    // Reset mid-session, then start+close together, then an empty session.
    applyStimulus(1'b1, 1'b0, MODE_MAJ, 1'b0, 32'h0, 8'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, MODE_MAJ, 1'b1, 32'hf00f000f, 8'h0f, 1'b1);
    applyStimulus(1'b0, 1'b0, MODE_MAJ, 1'b1, 32'hf00f000f, 8'h0f, 1'b1);
    idleCycle();
    checkOutput("t6 pre-reset yes", o_yes[0], 32'd88);
    pulseReset();
    applyStimulus(1'b1, 1'b0, MODE_MAJ, 1'b0, 32'h0, 8'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, MODE_MAJ, 1'b1, 32'hffffffff, 8'hff, 1'b1);
    applyStimulus(1'b1, 1'b1, MODE_MAJ, 1'b1, 32'hffffffff, 8'hff, 1'b1);
    idleCycle();
    checkOutput("t6 restart busy", 32'(o_busy[0]), 32'd1);
    checkOutput("t6 restart yes", o_yes[0], 32'd0);
    applyStimulus(1'b0, 1'b1, MODE_MAJ, 1'b0, 32'h0, 8'h0, 1'b0);
    idleCycle();
    checkOutput("t6 empty res_valid", 32'(o_rv[0]), 32'd1);
    checkOutput("t6 empty res", 32'(o_res[0]), 32'd0);

    // Randomized sessions.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #2;
      reset        = ($urandom_range(0, 299) == 0);
      start        = ($urandom_range(0, 39) == 0);
      close        = ($urandom_range(0, 24) == 0);
      mode         = 2'($urandom_range(0, 3));
      ballot_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       np = 32'hffffffff;
        1:       np = 32'h0;
        default: np = $urandom;
      endcase
      vip  = ($urandom_range(0, 1) != 0) ? 8'hff : 8'($urandom);
      vvip = 1'($urandom);
    end
    reset = 1'b0;
    repeat (4) idleCycle();
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("dut%0d predictions drained", k), 32'(sb_q[k].size()), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
